rsa_modexp_engine: RTL and testbench

//  Modular-exponentiation core computing C = M^E mod P, sitting directly downstream of the SPI register file.
//  P, E and M come straight from register-file bytes; start is a one-cycle pulse decoded from a control-register write.

---
 rtl/rsa_modexp_if.sv | 26 ++
 rtl/rsa_modexp_engine.sv | 132 +++++++++++++
 tb/tb_rsa_modexp_engine.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_if.sv
// Operand, control and status bundle between the register file and the modular-exponentiation core.
// Inputs are plain levels from the register file; start is a single-cycle pulse with no ready/ack return.
interface rsa_modexp_if #(
  parameter int WIDTH = 8
) ();
  logic             i_en;
  logic             i_start;
  logic [WIDTH-1:0] i_modulus;
  logic [WIDTH-1:0] i_exponent;
  logic [WIDTH-1:0] i_message;
  logic [WIDTH-1:0] o_result;
  logic             o_busy;
  logic             o_eoc;
  logic             o_err;
  logic [1:0]       o_state;

  modport master (
    output i_en, i_start, i_modulus, i_exponent, i_message,
    input  o_result, o_busy, o_eoc, o_err, o_state
  );

  modport slave (
    input  i_en, i_start, i_modulus, i_exponent, i_message,
    output o_result, o_busy, o_eoc, o_err, o_state
  );
endinterface

// File: rtl/rsa_modexp_engine.sv
// C = M^E mod P by left-to-right square-and-multiply, built on a bit-serial
// interleaved modular multiplier that consumes one multiplier bit per enabled cycle.
module rsa_modexp_engine #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         nrst,
  rsa_modexp_if.slave  bus
);
  localparam int KW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    SQR    = 2'd2,
    MUL    = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_p, r_e, r_m;
  logic [WIDTH-1:0] r_base, r_acc, r_r, r_result;
  logic [KW-1:0]    r_k, r_bit;
  logic             r_busy, r_eoc, r_err;

  logic [WIDTH-1:0] w_a, w_b, w_r_next;
  logic [WIDTH:0]   w_p_ext, w_dbl, w_dbl_red, w_add;
  logic             w_last;

  // Multiplier operands: REDUCE computes M*1 mod P, which reduces any M (and gives 0 for P==1).
  always_comb begin
    w_a = r_acc;
    w_b = r_acc;
    case (r_state)
      REDUCE:  begin w_a = r_m; w_b = WIDTH'(1); end
      MUL:     w_b = r_base;
      default: ;
    endcase
  end

  // One interleaved step: R < P on entry, so each partial sum is below 2P and needs one subtraction.
  assign w_p_ext   = {1'b0, r_p};
  assign w_dbl     = {r_r, 1'b0};
  assign w_dbl_red = (w_dbl >= w_p_ext) ? (w_dbl - w_p_ext) : w_dbl;
  assign w_add     = w_dbl_red + (w_a[r_bit] ? {1'b0, w_b} : '0);
  assign w_r_next  = WIDTH'((w_add >= w_p_ext) ? (w_add - w_p_ext) : w_add);
  assign w_last    = (r_bit == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= IDLE;
      r_p      <= '0;
      r_e      <= '0;
      r_m      <= '0;
      r_base   <= '0;
      r_acc    <= '0;
      r_r      <= '0;
      r_result <= '0;
      r_k      <= '0;
      r_bit    <= '0;
      r_busy   <= 1'b0;
      r_eoc    <= 1'b0;
      r_err    <= 1'b0;
    end else if (bus.i_en) begin
      if (r_state == IDLE) begin
        if (bus.i_start) begin
          r_p   <= bus.i_modulus;
          r_e   <= bus.i_exponent;
          r_m   <= bus.i_message;
          r_eoc <= 1'b0;
          r_err <= 1'b0;
          r_r   <= '0;
          r_k   <= KW'(WIDTH - 1);
          r_bit <= KW'(WIDTH - 1);
          if (bus.i_modulus == '0) begin
            r_err    <= 1'b1;
            r_eoc    <= 1'b1;
            r_result <= '0;
          end else begin
            r_busy  <= 1'b1;
            r_acc   <= (bus.i_modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
            r_state <= REDUCE;
          end
        end
      end else begin
        r_r   <= w_r_next;
        r_bit <= r_bit - KW'(1);
        if (w_last) begin
          r_r   <= '0;
          r_bit <= KW'(WIDTH - 1);
          case (r_state)
            REDUCE: begin
              r_base  <= w_r_next;
              r_state <= SQR;
            end
            SQR: begin
              r_acc <= w_r_next;
              if (r_e[r_k]) begin
                r_state <= MUL;
              end else if (r_k == '0) begin
                r_result <= w_r_next;
                r_eoc    <= 1'b1;
                r_busy   <= 1'b0;
                r_state  <= IDLE;
              end else begin
                r_k <= r_k - KW'(1);
              end
            end
            MUL: begin
              r_acc <= w_r_next;
              if (r_k == '0) begin
                r_result <= w_r_next;
                r_eoc    <= 1'b1;
                r_busy   <= 1'b0;
                r_state  <= IDLE;
              end else begin
                r_k     <= r_k - KW'(1);
                r_state <= SQR;
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.o_result = r_result;
  assign bus.o_busy   = r_busy;
  assign bus.o_eoc    = r_eoc;
  assign bus.o_err    = r_err;
  assign bus.o_state  = r_state;
endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed and randomized checks of rsa_modexp_engine against a repeated-multiplication model.
module tb_rsa_modexp_engine;
  logic clk;
  logic nrst;
  int   n_vec;
  int   n_err;
  int   last_res;

  rsa_modexp_if #(.WIDTH(8)) bus ();

  rsa_modexp_engine #(.WIDTH(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model(input int p, input int e, input int m);
    int r;
    if (p == 0) return 0;
    r = 1 % p;
    for (int i = 0; i < e; i++) r = (r * (m % p)) % p;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_start(input int p, input int e, input int m);
    @(negedge clk);
    bus.i_modulus  = p[7:0];
    bus.i_exponent = e[7:0];
    bus.i_message  = m[7:0];
    bus.i_start    = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
  endtask

  // dist_at: cycle at which a stray start with new operands is pulsed (0 = none).
  // en_at/en_len: cycle after which en is dropped for en_len cycles (0 = none).
  task automatic do_op(input int p, input int e, input int m,
                       input int dist_at, input int en_at, input int en_len);
    int exp_res, exp_lat, cyc;
    bit done, busy_ok, hold_ok;
    exp_res = model(p, e, m);
    exp_lat = 8 * (9 + $countones(e)) + en_len;
    pulse_start(p, e, m);
    if (p == 0) begin
      chk("p0_eoc", bus.o_eoc, 1);
      chk("p0_err", bus.o_err, 1);
      chk("p0_result", bus.o_result, 0);
      chk("p0_busy", bus.o_busy, 0);
      last_res = 0;
      return;
    end
    chk("accept_busy", bus.o_busy, 1);
    chk("accept_eoc", bus.o_eoc, 0);
    cyc = 0; done = 0; busy_ok = 1; hold_ok = 1;
    while (!done && cyc < 2000) begin
      @(posedge clk);
      #1 cyc++;
      if (bus.o_eoc) done = 1;
      else begin
        if (bus.o_busy !== 1'b1) busy_ok = 0;
        if (bus.o_result !== last_res[7:0]) hold_ok = 0;
      end
      if (dist_at != 0 && cyc == dist_at) begin
        bus.i_start    = 1'b1;
        bus.i_modulus  = 8'($urandom_range(1, 255));
        bus.i_exponent = 8'($urandom_range(0, 255));
        bus.i_message  = 8'($urandom_range(0, 255));
      end
      if (dist_at != 0 && cyc == dist_at + 1) bus.i_start = 1'b0;
      if (en_at != 0 && cyc == en_at) bus.i_en = 1'b0;
      if (en_at != 0 && cyc == en_at + en_len) bus.i_en = 1'b1;
    end
    bus.i_start = 1'b0;
    bus.i_en    = 1'b1;
    chk("eoc_reached", done, 1);
    chk("latency", cyc, exp_lat);
    chk("result", bus.o_result, exp_res);
    chk("err", bus.o_err, 0);
    chk("busy_at_eoc", bus.o_busy, 0);
    chk("busy_throughout", busy_ok, 1);
    chk("result_held", hold_ok, 1);
    last_res = exp_res;
  endtask

  initial begin
    int rp, re, rm;
    n_vec = 0; n_err = 0; last_res = 0;
    nrst = 1'b0;
    bus.i_en = 1'b1; bus.i_start = 1'b0;
    bus.i_modulus = '0; bus.i_exponent = '0; bus.i_message = '0;
    #13;
    chk("rst_result", bus.o_result, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_eoc", bus.o_eoc, 0);
    chk("rst_err", bus.o_err, 0);
    @(negedge clk) nrst = 1'b1;

    do_op(187, 7, 88, 0, 0, 0);
    chk("ref_187_7_88", last_res, 11);
    do_op(187, 23, 11, 0, 0, 0);
    chk("ref_187_23_11", last_res, 88);
    do_op(13, 1, 250, 0, 0, 0);
    chk("ref_13_1_250", last_res, 3);
    do_op(13, 0, 5, 0, 0, 0);
    chk("ref_13_0_5", last_res, 1);
    do_op(1, 5, 9, 0, 0, 0);
    do_op(0, 3, 4, 0, 0, 0);
    do_op(187, 7, 88, 20, 0, 0);
    do_op(187, 23, 11, 0, 30, 10);
    do_op(255, 255, 254, 0, 0, 0);

    // Asynchronous reset in the middle of a run.
    pulse_start(187, 23, 11);
    repeat (40) @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    chk("midrst_busy", bus.o_busy, 0);
    chk("midrst_eoc", bus.o_eoc, 0);
    chk("midrst_err", bus.o_err, 0);
    chk("midrst_result", bus.o_result, 0);
    last_res = 0;
    @(negedge clk) nrst = 1'b1;
    do_op(187, 7, 88, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      rp = (i == 5) ? 0 : $urandom_range(1, 255);
      re = $urandom_range(0, 255);
      rm = $urandom_range(0, 255);
      do_op(rp, re, rm, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
